// File: rtl/proj_fm_pkg.sv
// Shared types and helpers for the MinHash signature bank controller.
package proj_fm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_UPD_RD   = 3'd2,
        ST_UPD_CMP  = 3'd3,
        ST_DUMP_RD  = 3'd4,
        ST_DUMP_OUT = 3'd5
    } fm_ctrl_state_e;

    // Empty-slot value: all ones in the low 'width' bits, so any real hash wins the min.
    function automatic logic [63:0] FM_SLOT_INIT(input int width);
        return ~(64'hFFFF_FFFF_FFFF_FFFF << width);
    endfunction

endpackage

// File: rtl/proj_fm_ram.sv
// Single-port signature RAM with registered read data (read-before-write).
module proj_fm_ram #(
    parameter  int ENTRIES   = 128,
    parameter  int DATA_BITS = 8,
    localparam int ADDR_BITS = $clog2(ENTRIES)
) (
    input  logic                 in_clk,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic                 in_we,
    input  logic [DATA_BITS-1:0] in_wdata,
    output logic [DATA_BITS-1:0] out_rdata
);

    logic [DATA_BITS-1:0] r_mem [ENTRIES];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge in_clk) begin
        if (in_we) begin
            r_mem[in_addr] <= in_wdata;
        end
        r_rdata <= r_mem[in_addr];
    end

    assign out_rdata = r_rdata;

endmodule

// File: rtl/proj_fm_minhash_ctrl.sv
// Access controller for one MinHash signature bank: clear, read-compare-write
// min updates, and in-order signature dump over the RAM's single port.
module proj_fm_minhash_ctrl
    import proj_fm_pkg::*;
#(
    parameter  int ENTRIES   = 128,
    parameter  int DATA_BITS = 8,
    localparam int ADDR_BITS = $clog2(ENTRIES)
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_clear,
    input  logic                 in_dump,
    input  logic                 in_valid,
    input  logic [ADDR_BITS-1:0] in_idx,
    input  logic [DATA_BITS-1:0] in_hash,
    output logic                 out_ready,
    output logic                 out_sig_valid,
    output logic [ADDR_BITS-1:0] out_sig_idx,
    output logic [DATA_BITS-1:0] out_sig_data,
    input  logic                 in_sig_ready,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [ADDR_BITS-1:0] out_ram_addr,
    output logic                 out_ram_we,
    output logic [DATA_BITS-1:0] out_ram_wdata,
    input  logic [DATA_BITS-1:0] in_ram_rdata,
    output logic [2:0]           out_dbg_state
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(ENTRIES - 1);

    // Handshakes: an update transfers on a rising edge where in_valid & out_ready;
    // a dump beat transfers where out_sig_valid & in_sig_ready. Held values stay
    // stable until their transfer.

    fm_ctrl_state_e       r_state;
    fm_ctrl_state_e       w_state_nxt;
    logic [ADDR_BITS-1:0] r_cnt;
    logic [ADDR_BITS-1:0] w_cnt_nxt;
    logic [ADDR_BITS-1:0] r_idx;
    logic [DATA_BITS-1:0] r_hash;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_latch;
    logic [DATA_BITS-1:0] w_slot_init;

    assign w_slot_init   = DATA_BITS'(FM_SLOT_INIT(DATA_BITS));
    assign out_busy      = (r_state != ST_IDLE);
    assign out_done      = r_done;
    assign out_dbg_state = r_state;
    // Gated by reset so every output reads 0 while reset is held.
    assign out_ready     = in_rst_n & (r_state == ST_IDLE) & ~in_clear & ~in_dump;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_latch       = 1'b0;
        out_ram_addr  = '0;
        out_ram_we    = 1'b0;
        out_ram_wdata = '0;
        out_sig_valid = 1'b0;
        out_sig_idx   = '0;
        out_sig_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (in_clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (in_dump) begin
                    w_state_nxt = ST_DUMP_RD;
                    w_cnt_nxt   = '0;
                end else if (in_valid) begin
                    w_state_nxt = ST_UPD_RD;
                    w_latch     = 1'b1;
                end
            end
            ST_CLEAR: begin
                out_ram_addr  = r_cnt;
                out_ram_we    = 1'b1;
                out_ram_wdata = w_slot_init;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_UPD_RD: begin
                out_ram_addr = r_idx;
                w_state_nxt  = ST_UPD_CMP;
            end
            ST_UPD_CMP: begin
                // Strict unsigned compare: an equal hash leaves the slot untouched.
                out_ram_addr  = r_idx;
                out_ram_wdata = r_hash;
                out_ram_we    = (r_hash < in_ram_rdata);
                w_state_nxt   = ST_IDLE;
            end
            ST_DUMP_RD: begin
                out_ram_addr = r_cnt;
                w_state_nxt  = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                out_ram_addr  = r_cnt;
                out_sig_valid = 1'b1;
                out_sig_idx   = r_cnt;
                out_sig_data  = in_ram_rdata;
                if (in_sig_ready) begin
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_DUMP_RD;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_hash  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_idx  <= in_idx;
                r_hash <= in_hash;
            end
        end
    end

endmodule
